vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised video timing generator for the VGA pixel-clock domain. It produces horizontal/vertical sync, data-enable, pixel coordinates and frame/line strobes for any resolution selected by parameters, replacing the fixed 640x480 timing. Sync and data-enable can be delayed by a configurable number of cycles to line up with the pixel-fetch pipeline. A `pause` input freezes scanning between frames so the CPU side can hold off video.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `H_POL`, 0, hsync active level (0 = active-low)
- `V_POL`, 0, vsync active level
- `PIPE_DELAY`, 2, extra register stages on hs/vs/de (0..15)

- `clk_vga`  in  1  pixel clock; the only clock
- `rst`  in  1  synchronous reset, active-high
- `pause`  in  1  request to hold scanning at the next frame boundary
- `x`  out  XW  horizontal counter, XW = clog2(H_TOTAL)
- `y`  out  YW  vertical counter, YW = clog2(V_TOTAL)
- `line_start`  out  1  one-cycle strobe, x==0
- `frame_start`  out  1  one-cycle strobe, x==0 && y==0
- `paused`  out  1  generator is held at frame boundary
- `vga_hs`  out  1  horizontal sync, delayed by PIPE_DELAY
- `vga_vs`  out  1  vertical sync, delayed by PIPE_DELAY
- `vga_de`  out  1  data enable, delayed by PIPE_DELAY

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Line order: active, front porch, sync, back porch.
- States: RUN, HOLD. Reset enters RUN with x=0, y=0.
- RUN: x increments each cycle; at x==H_TOTAL-1, x wraps to 0 and y increments; at y==V_TOTAL-1 and x==H_TOTAL-1, both wrap to 0.
- RUN -> HOLD when `pause` is 1 on the cycle x==H_TOTAL-1 && y==V_TOTAL-1; counters still wrap to 0,0, then freeze. `pause` at any other point only arms nothing; it is sampled solely at the last pixel of a frame.
- HOLD: x=0, y=0 frozen; `frame_start`/`line_start` held 0; hs/vs at inactive level, de=0. HOLD -> RUN on the first cycle `pause`==0; that cycle's outputs are the first pixel of a new frame (`frame_start`=1).
- `paused` = 1 exactly while in HOLD.
- Raw decode (from counters): de_raw = x<H_ACTIVE && y<V_ACTIVE; hs_raw = x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs_raw = y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), whole lines. Raw decodes forced inactive in HOLD.
- Output levels: vga_hs = hs_raw ? H_POL : ~H_POL; same for vs.
- Reset values: x=0, y=0, line_start=0, frame_start=0, paused=0, vga_de=0, vga_hs=~H_POL, vga_vs=~V_POL, all delay stages cleared to inactive.
- Reset mid-frame: next cycle restarts at 0,0 in RUN regardless of `pause`.

## Timing
- x, y, line_start, frame_start, paused are registered; valid the cycle after the counter update (latency 0 relative to x/y).
- vga_hs/vs/de lag x/y by 1+PIPE_DELAY cycles (1 decode register + PIPE_DELAY stages).
- Strobes: line_start high for exactly one cycle per line; frame_start once per frame (line_start also high that cycle).
- Frame period in RUN: H_TOTAL*V_TOTAL cycles exactly; hsync pulse H_SYNC cycles; vsync pulse V_SYNC*H_TOTAL cycles.
- Elaboration rejects any zero porch/sync/active parameter and PIPE_DELAY>15.

## Structure
- Shared package `vga_pkg`: mode constant sets (640x480, 720x400, 720x480, 800x600, 1280x720) as parameter bundles, plus `clog2` helper.
- One sub-module: `sync_delay` — parametrised-depth shift register, 3 bits wide, with synchronous reset to a supplied inactive pattern.

## Test plan
- Default params, release reset: vga_hs low for 96 cycles starting 656+1+2 cycles after first x==0; line period 800; frame period 420000.
- Count vga_de=1 cycles over one frame -> 307200; vsync low for 1600 cycles.
- `pause`=1 held from mid-frame -> frame completes, paused=1 from cycle after x=799,y=524; x,y stay 0; de=0; release -> frame_start=1 that cycle.
- `pause` pulsed at x=100,y=200 only -> no HOLD, frame period unchanged.
- rst asserted at x=300,y=300 -> next cycle x=0,y=0, hs/vs inactive (1), de=0, delay line flushed.
- 800x600 bundle with H_POL=V_POL=1, PIPE_DELAY=0 -> H_TOTAL 1056, V_TOTAL 628, hs high for 128 cycles lagging counters by 1.

Source files
------------

// File: rtl/vga_pkg.sv
// Video mode parameter bundles and a width helper shared by the timing generator.
// Mode fields follow line order: active, front porch, sync, back porch.
package vga_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } vga_mode_t;

    localparam vga_mode_t MODE_640X480 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2, v_bp: 33
    };
    localparam vga_mode_t MODE_720X400 = '{
        h_active: 720, h_fp: 18, h_sync: 108, h_bp: 54,
        v_active: 400, v_fp: 12, v_sync: 2, v_bp: 35
    };
    localparam vga_mode_t MODE_720X480 = '{
        h_active: 720, h_fp: 16, h_sync: 62, h_bp: 60,
        v_active: 480, v_fp: 9, v_sync: 6, v_bp: 30
    };
    localparam vga_mode_t MODE_800X600 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1, v_sync: 4, v_bp: 23
    };
    localparam vga_mode_t MODE_1280X720 = '{
        h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
        v_active: 720, v_fp: 5, v_sync: 5, v_bp: 20
    };

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } scan_state_e;

    // Bits needed to count 0..value-1; never less than one.
    function automatic int clog2(input int unsigned value);
        int result = 0;
        while ((64'd1 << result) < 64'(value)) result++;
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// Purpose: fixed-depth 3-bit shift register that resets to a given idle pattern.
// Latency: DEPTH cycles from levels to delayed.
// Backpressure: none; shifts every clock.
module sync_delay #(
    parameter int         DEPTH    = 1,
    parameter logic [2:0] INACTIVE = 3'b000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] levels,
    output logic [2:0] delayed
);

    logic [2:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= INACTIVE;
        end else begin
            stage[0] <= levels;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: parametrised raster timing (counters, strobes, hs/vs/de) for the pixel clock.
// Latency: x/y/strobes registered together; hs/vs/de trail x/y by 1+PIPE_DELAY cycles.
// Backpressure: none while running; pause holds at 0,0 only when seen on a frame's last pixel.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_POL      = 1'b0,
    parameter bit V_POL      = 1'b0,
    parameter int PIPE_DELAY = 2,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW        = clog2(H_TOTAL),
    localparam int YW        = clog2(V_TOTAL)
) (
    input  logic          clk_vga,
    input  logic          rst,
    input  logic          pause,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          paused,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          vga_de
);

    if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
        V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 ||
        PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_param_check
        $error("vga_timing_gen: zero timing field or PIPE_DELAY outside 0..15");
    end

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_HS_BEG = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] X_HS_END = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] Y_VS_BEG = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] Y_VS_END = YW'(V_ACTIVE + V_FP + V_SYNC);

    scan_state_e   state_q, state_d;
    logic [XW-1:0] x_d;
    logic [YW-1:0] y_d;
    logic          line_d, frame_d;
    logic          run;
    logic          de_raw, hs_raw, vs_raw;
    logic [2:0]    levels, delayed;

    always_comb begin
        state_d = state_q;
        x_d     = x;
        y_d     = y;
        case (state_q)
            ST_RUN: begin
                if (x == X_LAST) begin
                    x_d = '0;
                    if (y == Y_LAST) begin
                        y_d = '0;
                        // pause is only honoured on the last pixel of a frame
                        if (pause) state_d = ST_HOLD;
                    end else begin
                        y_d = y + YW'(1);
                    end
                end else begin
                    x_d = x + XW'(1);
                end
            end
            ST_HOLD: begin
                if (!pause) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        line_d  = (state_d == ST_RUN) && (x_d == '0);
        frame_d = line_d && (y_d == '0);
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            state_q     <= ST_RUN;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            x           <= x_d;
            y           <= y_d;
            line_start  <= line_d;
            frame_start <= frame_d;
        end
    end

    assign paused = (state_q == ST_HOLD);

    // Decode from the registered counters; the delay line's first stage is the decode register.
    always_comb begin
        run    = (state_q == ST_RUN);
        de_raw = run && (x < X_ACT) && (y < Y_ACT);
        hs_raw = run && (x >= X_HS_BEG) && (x < X_HS_END);
        vs_raw = run && (y >= Y_VS_BEG) && (y < Y_VS_END);
        levels = {de_raw, vs_raw ? V_POL : ~V_POL, hs_raw ? H_POL : ~H_POL};
    end

    sync_delay #(
        .DEPTH    (PIPE_DELAY + 1),
        .INACTIVE ({1'b0, ~V_POL, ~H_POL})
    ) u_sync_delay (
        .clk     (clk_vga),
        .rst     (rst),
        .levels  (levels),
        .delayed (delayed)
    );

    assign vga_de = delayed[2];
    assign vga_vs = delayed[1];
    assign vga_hs = delayed[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: small-mode table vectors, frame statistics and a randomized run against a position model,
// plus default-mode and 800x600 positive-polarity instances for sync placement and line period.
module tb_vga_timing_gen;
    import vga_pkg::*;

    // Small mode: line 25 (16+2+3+4), frame 11 lines (6+1+2+2), active-low syncs, 2 extra stages.
    localparam int S_HA = 16, S_HFP = 2, S_HSY = 3, S_HBP = 4;
    localparam int S_VA = 6,  S_VFP = 1, S_VSY = 2, S_VBP = 2;
    localparam int S_PD = 2;
    localparam int S_HT = S_HA + S_HFP + S_HSY + S_HBP;
    localparam int S_VT = S_VA + S_VFP + S_VSY + S_VBP;
    localparam int S_FRAME = S_HT * S_VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Small-mode instance
    logic       rst_s = 1'b1, pause_s = 1'b0;
    logic [4:0] x_s;
    logic [3:0] y_s;
    logic       ls_s, fs_s, paused_s, hs_s, vs_s, de_s;

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSY), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSY), .V_BP(S_VBP),
        .H_POL(1'b0), .V_POL(1'b0), .PIPE_DELAY(S_PD)
    ) dut_s (
        .clk_vga(clk), .rst(rst_s), .pause(pause_s), .x(x_s), .y(y_s),
        .line_start(ls_s), .frame_start(fs_s), .paused(paused_s),
        .vga_hs(hs_s), .vga_vs(vs_s), .vga_de(de_s)
    );

    // Default 640x480 instance
    logic       rst_d = 1'b1, done_d = 1'b0;
    logic [9:0] x_d, y_d;
    logic       ls_d, fs_d, paused_d, hs_d, vs_d, de_d;

    vga_timing_gen dut_d (
        .clk_vga(clk), .rst(rst_d), .pause(1'b0), .x(x_d), .y(y_d),
        .line_start(ls_d), .frame_start(fs_d), .paused(paused_d),
        .vga_hs(hs_d), .vga_vs(vs_d), .vga_de(de_d)
    );

    // 800x600, active-high syncs, no extra stages
    logic        rst_w = 1'b1, done_w = 1'b0;
    logic [10:0] x_w;
    logic [9:0]  y_w;
    logic        ls_w, fs_w, paused_w, hs_w, vs_w, de_w;

    vga_timing_gen #(
        .H_ACTIVE(MODE_800X600.h_active), .H_FP(MODE_800X600.h_fp),
        .H_SYNC(MODE_800X600.h_sync), .H_BP(MODE_800X600.h_bp),
        .V_ACTIVE(MODE_800X600.v_active), .V_FP(MODE_800X600.v_fp),
        .V_SYNC(MODE_800X600.v_sync), .V_BP(MODE_800X600.v_bp),
        .H_POL(1'b1), .V_POL(1'b1), .PIPE_DELAY(0)
    ) dut_w (
        .clk_vga(clk), .rst(rst_w), .pause(1'b0), .x(x_w), .y(y_w),
        .line_start(ls_w), .frame_start(fs_w), .paused(paused_w),
        .vga_hs(hs_w), .vga_vs(vs_w), .vga_de(de_w)
    );

    // Table records: apply rst/pause for n edges, then compare every output.
    typedef struct {
        bit rst; bit pause; int n;
        int ex; int ey; bit ls; bit fs; bit pd; bit de; bit hs; bit vs;
    } vec_t;

    function automatic vec_t mk(bit r, bit p, int n, int ex, int ey,
                                bit ls, bit fs, bit pd, bit de, bit hs, bit vs);
        vec_t v;
        v.rst = r; v.pause = p; v.n = n; v.ex = ex; v.ey = ey;
        v.ls = ls; v.fs = fs; v.pd = pd; v.de = de; v.hs = hs; v.vs = vs;
        return v;
    endfunction

    function automatic logic [14:0] exp_vec(vec_t v);
        return {5'(v.ex), 4'(v.ey), v.ls, v.fs, v.pd, v.de, v.hs, v.vs};
    endfunction

    // Reference model: a linear position within the frame plus a hold flag;
    // sync/de come from a history of per-cycle decodes read PIPE_DELAY entries back.
    int         m_pos;
    bit         m_hold, m_ls, m_fs;
    logic [2:0] m_hist[$];

    function automatic logic [2:0] m_decode(int pos, bit hold);
        int hx, vy;
        bit de, hs_act, vs_act;
        hx = pos % S_HT;
        vy = pos / S_HT;
        de     = !hold && hx < S_HA && vy < S_VA;
        hs_act = !hold && hx >= S_HA + S_HFP && hx < S_HA + S_HFP + S_HSY;
        vs_act = !hold && vy >= S_VA + S_VFP && vy < S_VA + S_VFP + S_VSY;
        return {de, ~hs_act, ~vs_act};
    endfunction

    task automatic model_step(input bit r, input bit p);
        if (r) begin
            m_pos = 0; m_hold = 0; m_ls = 0; m_fs = 0;
            m_hist.delete();
            repeat (S_PD + 1) m_hist.push_back(3'b011);
        end else begin
            m_hist.push_front(m_decode(m_pos, m_hold));
            void'(m_hist.pop_back());
            if (m_hold) begin
                m_ls = !p; m_fs = !p;
                if (!p) m_hold = 0;
            end else if (m_pos == S_FRAME - 1) begin
                m_pos = 0; m_hold = p; m_ls = !p; m_fs = !p;
            end else begin
                m_pos++;
                m_ls = (m_pos % S_HT) == 0;
                m_fs = 0;
            end
        end
    endtask

    function automatic logic [14:0] model_vec();
        return {5'(m_pos % S_HT), 4'(m_pos / S_HT), m_ls, m_fs, m_hold, m_hist[S_PD]};
    endfunction

    vec_t tbl [26];

    initial begin : main
        int w, de_cnt, vs_cnt, hs_cnt, ls_cnt, fs_cnt, left;
        tbl[0]  = mk(1, 0,   1,  0,  0, 0, 0, 0, 0, 1, 1);
        tbl[1]  = mk(0, 0,   1,  1,  0, 0, 0, 0, 0, 1, 1);
        tbl[2]  = mk(0, 0,   2,  3,  0, 0, 0, 0, 1, 1, 1);
        tbl[3]  = mk(0, 0,  15, 18,  0, 0, 0, 0, 1, 1, 1);
        tbl[4]  = mk(0, 0,   1, 19,  0, 0, 0, 0, 0, 1, 1);
        tbl[5]  = mk(0, 0,   3, 22,  0, 0, 0, 0, 0, 0, 1);
        tbl[6]  = mk(0, 0,   3,  0,  1, 1, 0, 0, 0, 1, 1);
        tbl[7]  = mk(0, 0,   1,  1,  1, 0, 0, 0, 0, 1, 1);
        tbl[8]  = mk(0, 0, 149,  0,  7, 1, 0, 0, 0, 1, 1);
        tbl[9]  = mk(0, 0,   3,  3,  7, 0, 0, 0, 0, 1, 0);
        tbl[10] = mk(0, 0,  96, 24, 10, 0, 0, 0, 0, 1, 1);
        tbl[11] = mk(0, 1,   1,  0,  0, 0, 0, 1, 0, 1, 1);
        tbl[12] = mk(0, 1,   5,  0,  0, 0, 0, 1, 0, 1, 1);
        tbl[13] = mk(0, 0,   1,  0,  0, 1, 1, 0, 0, 1, 1);
        tbl[14] = mk(0, 0,   1,  1,  0, 0, 0, 0, 0, 1, 1);
        tbl[15] = mk(0, 0,   2,  3,  0, 0, 0, 0, 1, 1, 1);
        tbl[16] = mk(1, 0,   1,  0,  0, 0, 0, 0, 0, 1, 1);
        tbl[17] = mk(0, 1,   1,  1,  0, 0, 0, 0, 0, 1, 1);
        tbl[18] = mk(0, 0, 273, 24, 10, 0, 0, 0, 0, 1, 1);
        tbl[19] = mk(0, 0,   1,  0,  0, 1, 1, 0, 0, 1, 1);
        tbl[20] = mk(0, 1, 150,  0,  6, 1, 0, 0, 0, 1, 1);
        tbl[21] = mk(0, 1, 124, 24, 10, 0, 0, 0, 0, 1, 1);
        tbl[22] = mk(0, 1,   1,  0,  0, 0, 0, 1, 0, 1, 1);
        tbl[23] = mk(1, 1,   1,  0,  0, 0, 0, 0, 0, 1, 1);
        tbl[24] = mk(0, 1,   1,  1,  0, 0, 0, 0, 0, 1, 1);
        tbl[25] = mk(0, 1,   2,  3,  0, 0, 0, 0, 1, 1, 1);

        @(negedge clk);
        for (int i = 0; i < 26; i++) begin
            rst_s = tbl[i].rst;
            pause_s = tbl[i].pause;
            repeat (tbl[i].n) @(negedge clk);
            check($sformatf("vec%0d", i),
                  64'({x_s, y_s, ls_s, fs_s, paused_s, de_s, hs_s, vs_s}),
                  64'(exp_vec(tbl[i])));
        end

        // One full steady-state frame of statistics.
        rst_s = 1'b1; pause_s = 1'b0;
        @(negedge clk);
        rst_s = 1'b0;
        w = 0;
        while (fs_s !== 1'b1 && w < 700) begin @(negedge clk); w++; end
        check("s_first_frame", 64'(w), 64'(S_FRAME));
        de_cnt = 0; vs_cnt = 0; hs_cnt = 0; ls_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < S_FRAME; i++) begin
            de_cnt += int'(de_s);
            vs_cnt += int'(!vs_s);
            hs_cnt += int'(!hs_s);
            ls_cnt += int'(ls_s);
            fs_cnt += int'(fs_s);
            @(negedge clk);
        end
        check("s_de_count",  64'(de_cnt), 64'(S_HA * S_VA));
        check("s_vs_low",    64'(vs_cnt), 64'(S_VSY * S_HT));
        check("s_hs_low",    64'(hs_cnt), 64'(S_HSY * S_VT));
        check("s_ls_count",  64'(ls_cnt), 64'(S_VT));
        check("s_fs_count",  64'(fs_cnt), 64'(1));
        check("s_frame_period", 64'(fs_s), 64'(1));

        // Randomized pause/reset against the model.
        rst_s = 1'b1; pause_s = 1'b0; left = 0;
        @(posedge clk);
        model_step(1'b1, 1'b0);
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            check("rand", 64'({x_s, y_s, ls_s, fs_s, paused_s, de_s, hs_s, vs_s}),
                  64'(model_vec()));
            if (left == 0) begin
                pause_s = 1'($urandom_range(0, 1));
                left = $urandom_range(1, 400);
            end
            left--;
            rst_s = ($urandom_range(0, 699) == 0);
            @(posedge clk);
            model_step(rst_s, pause_s);
        end
        @(negedge clk);
        check("rand_last", 64'({x_s, y_s, ls_s, fs_s, paused_s, de_s, hs_s, vs_s}),
              64'(model_vec()));

        w = 0;
        while (!(done_d && done_w) && w < 10000) begin @(negedge clk); w++; end
        check("aux_done", 64'({done_d, done_w}), 64'(2'b11));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : proc_default
        int n;
        repeat (3) @(negedge clk);
        check("d_reset", 64'({x_d, y_d, ls_d, fs_d, paused_d, de_d, hs_d, vs_d}),
              64'({10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}));
        rst_d = 1'b0;
        n = 0;
        while (hs_d !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        check("d_hs_start", 64'(n), 64'(656 + 1 + 2));
        n = 0;
        while (hs_d === 1'b0 && n < 2000) begin @(negedge clk); n++; end
        check("d_hs_width", 64'(n), 64'(96));
        n = 0;
        while (ls_d !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        check("d_line1_y", 64'(y_d), 64'(1));
        @(negedge clk);
        n = 1;
        while (ls_d !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        check("d_line_period", 64'(n), 64'(800));
        done_d = 1'b1;
    end

    initial begin : proc_wide
        int n, xmax;
        repeat (3) @(negedge clk);
        check("w_reset", 64'({x_w, y_w, ls_w, fs_w, paused_w, de_w, hs_w, vs_w}),
              64'({11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        rst_w = 1'b0;
        n = 0;
        while (hs_w !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        check("w_hs_start", 64'(n), 64'(840 + 1));
        n = 0;
        while (hs_w === 1'b1 && n < 3000) begin @(negedge clk); n++; end
        check("w_hs_width", 64'(n), 64'(128));
        n = 0;
        while (ls_w !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        check("w_line1_y", 64'(y_w), 64'(1));
        @(negedge clk);
        n = 1; xmax = 0;
        while (ls_w !== 1'b1 && n < 3000) begin
            if (int'(x_w) > xmax) xmax = int'(x_w);
            @(negedge clk);
            n++;
        end
        check("w_line_period", 64'(n), 64'(1056));
        check("w_x_max", 64'(xmax), 64'(1055));
        done_w = 1'b1;
    end

endmodule
